// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequential ALU with AC/E/MQ registers and a start/busy/done handshake
//
// Purpose: accumulator ALU for the basic computer datapath. Logic and arithmetic
// ops finish in one cycle. Circulates through the {AC,E} ring move one bit per
// cycle. Unsigned multiply is a W-step shift-add into {MQ,AC}.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op, dr,    launch an op. op/dr/shamt are sampled with start.
//   shamt             start is accepted only while busy=0.
//   ld_ac, ac_in      load AC directly while idle. start has priority over ld_ac.
//   ac, e, mq         architectural registers
//   busy, done        multi-cycle op in progress / one-cycle completion pulse
//   co, ovf           carry and signed overflow of the last ADD/SUB/INC
//   n, z              sign and zero of AC
//   err               sticky illegal-op flag, cleared by the next accepted start
module alu_seq_unit #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic [W-1:0]   dr,
  input  logic [SHW-1:0] shamt,
  input  logic           ld_ac,
  input  logic [W-1:0]   ac_in,
  output logic [W-1:0]   ac,
  output logic           e,
  output logic [W-1:0]   mq,
  output logic           busy,
  output logic           done,
  output logic           co,
  output logic           ovf,
  output logic           n,
  output logic           z,
  output logic           err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_CMA = 4'd3;
  localparam logic [3:0] OP_CIR = 4'd4;
  localparam logic [3:0] OP_CIL = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_CLE = 4'd8;
  localparam logic [3:0] OP_CME = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t         state, state_d;
  logic [SHW-1:0] rem;       // steps still to perform after the current edge
  logic [W-1:0]   mcand;     // multiplicand held for the whole multiply
  logic           dir_left;  // direction of the circulate in progress

  logic [W:0]     add_sum, sub_sum, inc_sum;
  logic [W-1:0]   mul_base, mul_addend;
  logic [W:0]     mul_sum;
  logic           rot_left;
  logic [W-1:0]   rot_ac;
  logic           rot_e;

  // DONE accepts a new start exactly like IDLE, so back-to-back ops need no gap.
  assign busy = (state == SHIFT) || (state == MUL);
  assign done = (state == DONE);
  assign n    = ac[W-1];
  assign z    = (ac == '0);

  assign add_sum = {1'b0, ac} + {1'b0, dr};
  assign sub_sum = {1'b0, ac} + {1'b0, ~dr} + (W+1)'(1);
  assign inc_sum = {1'b0, ac} + (W+1)'(1);

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (ac[0]) is set, then shift {carry,mq,ac} right.
  // The first step happens on the start edge, where mq is treated as zero
  // and the multiplicand comes straight from dr.
  always_comb begin
    mul_base   = '0;
    mul_addend = '0;
    if (state == MUL) begin
      mul_base   = mq;
      mul_addend = ac[0] ? mcand : '0;
    end else begin
      mul_addend = ac[0] ? dr : '0;
    end
    mul_sum = {1'b0, mul_base} + {1'b0, mul_addend};
  end

  // Single-bit rotate of the W+1-bit ring {ac,e}.
  always_comb begin
    rot_left = (state == SHIFT) ? dir_left : (op == OP_CIL);
    rot_ac   = rot_left ? {ac[W-2:0], e} : {e, ac[W-1:1]};
    rot_e    = rot_left ? ac[W-1] : ac[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          case (op)
            OP_CIR, OP_CIL: state_d = (shamt > SHW'(1)) ? SHIFT : DONE;
            OP_MUL:         state_d = MUL;
            default:        state_d = DONE;
          endcase
        end
      end
      SHIFT, MUL: begin
        if (rem == SHW'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac       <= '0;
      e        <= 1'b0;
      mq       <= '0;
      co       <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      rem      <= '0;
      mcand    <= '0;
      dir_left <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err <= (op > OP_MUL);
            case (op)
              OP_ADD: begin
                ac  <= add_sum[W-1:0];
                e   <= add_sum[W];
                co  <= add_sum[W];
                ovf <= (ac[W-1] == dr[W-1]) && (add_sum[W-1] != ac[W-1]);
              end
              OP_AND: ac <= ac & dr;
              OP_LDA: ac <= dr;
              OP_CMA: ac <= ~ac;
              OP_CIR, OP_CIL: begin
                if (shamt != '0) begin
                  ac <= rot_ac;
                  e  <= rot_e;
                end
                rem      <= shamt - SHW'(1);
                dir_left <= (op == OP_CIL);
              end
              OP_SUB: begin
                ac  <= sub_sum[W-1:0];
                e   <= sub_sum[W];
                co  <= sub_sum[W];
                ovf <= (ac[W-1] != dr[W-1]) && (sub_sum[W-1] != ac[W-1]);
              end
              OP_INC: begin
                ac  <= inc_sum[W-1:0];
                e   <= inc_sum[W];
                co  <= inc_sum[W];
                ovf <= !ac[W-1] && inc_sum[W-1];
              end
              OP_CLE: e <= 1'b0;
              OP_CME: e <= ~e;
              OP_MUL: begin
                mq    <= mul_sum[W:1];
                ac    <= {mul_sum[0], ac[W-1:1]};
                mcand <= dr;
                rem   <= SHW'(W-1);
              end
              default: ;
            endcase
          end else if (ld_ac) begin
            ac <= ac_in;
          end
        end
        SHIFT: begin
          ac  <= rot_ac;
          e   <= rot_e;
          rem <= rem - SHW'(1);
        end
        MUL: begin
          mq  <= mul_sum[W:1];
          ac  <= {mul_sum[0], ac[W-1:1]};
          rem <= rem - SHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - randomized self-checking bench for alu_seq_unit against an arithmetic model
module tb_alu_seq_unit;
  localparam int W   = 16;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op = '0;
  logic [W-1:0]   dr = '0;
  logic [SHW-1:0] shamt = '0;
  logic           ld_ac = 1'b0;
  logic [W-1:0]   ac_in = '0;
  logic [W-1:0]   ac, mq;
  logic           e, busy, done, co, ovf, n, z, err;

  alu_seq_unit #(.W(W), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dr(dr), .shamt(shamt),
    .ld_ac(ld_ac), .ac_in(ac_in), .ac(ac), .e(e), .mq(mq), .busy(busy),
    .done(done), .co(co), .ovf(ovf), .n(n), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_ac, m_mq;
  logic         m_e, m_co, m_ovf, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ac = '0; m_mq = '0; m_e = 0; m_co = 0; m_ovf = 0; m_err = 0;
  endtask

  // Architectural effect of one op, from the instruction definitions.
  task automatic model_op(input logic [3:0] o, input logic [W-1:0] d, input logic [SHW-1:0] k);
    logic [16:0] s, ring;
    logic [31:0] p;
    int kk;
    m_err = (o > 4'd10);
    case (o)
      4'd0: begin
        s = {1'b0, m_ac} + {1'b0, d};
        m_ovf = (m_ac[15] == d[15]) && (s[15] != m_ac[15]);
        m_ac = s[15:0]; m_e = s[16]; m_co = s[16];
      end
      4'd1: m_ac = m_ac & d;
      4'd2: m_ac = d;
      4'd3: m_ac = ~m_ac;
      4'd4, 4'd5: begin
        ring = {m_e, m_ac};
        kk = int'(k) % 17;
        if (o == 4'd4) ring = (ring >> kk) | (ring << (17 - kk));
        else           ring = (ring << kk) | (ring >> (17 - kk));
        {m_e, m_ac} = ring;
      end
      4'd6: begin
        s = {1'b0, m_ac} + {1'b0, ~d} + 17'd1;
        m_ovf = (m_ac[15] != d[15]) && (s[15] != m_ac[15]);
        m_ac = s[15:0]; m_e = s[16]; m_co = s[16];
      end
      4'd7: begin
        s = {1'b0, m_ac} + 17'd1;
        m_ovf = !m_ac[15] && s[15];
        m_ac = s[15:0]; m_e = s[16]; m_co = s[16];
      end
      4'd8: m_e = 1'b0;
      4'd9: m_e = ~m_e;
      4'd10: begin
        p = {16'd0, m_ac} * {16'd0, d};
        m_mq = p[31:16]; m_ac = p[15:0];
      end
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [3:0] o, input logic [SHW-1:0] k);
    if ((o == 4'd4 || o == 4'd5) && k != 0) return int'(k);
    if (o == 4'd10) return 16;
    return 1;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".ac"}, ac, m_ac);
    chk({tag, ".e"}, e, m_e);
    chk({tag, ".mq"}, mq, m_mq);
    chk({tag, ".co"}, co, m_co);
    chk({tag, ".ovf"}, ovf, m_ovf);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".n"}, n, m_ac[15]);
    chk({tag, ".z"}, z, m_ac == 0);
  endtask

  task automatic ldac(input logic [W-1:0] v);
    ld_ac = 1; ac_in = v;
    tick();
    ld_ac = 0;
    m_ac = v;
    chk("ldac.ac", ac, v);
    chk("ldac.done", done, 0);
    chk("ldac.e", e, m_e);
  endtask

  // Issue one op and follow it to its done pulse. poke drives start/ld_ac
  // with junk every busy cycle; with_ld raises ld_ac together with start.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] d, input logic [SHW-1:0] k,
                        input bit with_ld, input bit poke);
    int cyc, bcnt, lat;
    start = 1; op = o; dr = d; shamt = k; ld_ac = with_ld; ac_in = W'($urandom);
    tick();
    start = 0; ld_ac = 0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) begin
        bcnt++;
        if (poke) begin
          start = 1; op = 4'($urandom_range(0, 15)); dr = W'($urandom);
          shamt = SHW'($urandom); ld_ac = 1; ac_in = W'($urandom);
        end
      end
      tick();
      start = 0; ld_ac = 0;
      cyc++;
    end
    model_op(o, d, k);
    lat = exp_lat(o, k);
    chk("done", done, 1);
    chk("latency", cyc, lat);
    chk("busy_cycles", bcnt, lat - 1);
    chk("busy_at_done", busy, 0);
    check_regs($sformatf("op%0d", o));
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst.ac", ac, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    tick(); tick();
    rst_n = 1;
    check_regs("rst");

    // Directed cases
    ldac(16'h7FFF);
    run_op(4'd0, 16'h0001, 0, 0, 0);
    chk("add_ovf.ac", ac, 16'h8000);
    chk("add_ovf.ovf", ovf, 1);
    tick();
    chk("done_clears", done, 0);

    ldac(16'hFFFF);
    run_op(4'd0, 16'h0001, 0, 0, 0);
    chk("add_wrap.z", z, 1);
    chk("add_wrap.co", co, 1);

    ldac(16'd5);
    run_op(4'd6, 16'd7, 0, 0, 0);
    chk("sub.ac", ac, 16'hFFFE);

    ldac(16'h0001);
    run_op(4'd8, 0, 0, 0, 0);
    run_op(4'd4, 0, 5'd4, 0, 0);
    chk("cir4.ac", ac, 16'h2000);
    run_op(4'd4, 0, 5'd0, 0, 0);
    run_op(4'd5, 0, 5'd17, 0, 1);
    run_op(4'd5, 0, 5'd1, 0, 0);

    ldac(16'h1234);
    run_op(4'd10, 16'h0100, 0, 0, 1);
    chk("mul.ac", ac, 16'h3400);
    chk("mul.mq", mq, 16'h0012);

    // Asynchronous reset in the middle of a multiply
    ldac(16'hABCD);
    start = 1; op = 4'd10; dr = 16'h5678;
    tick();
    start = 0;
    repeat (6) tick();
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    check_regs("midrst");
    tick();
    rst_n = 1;
    tick();
    run_op(4'd0, 16'h0003, 0, 0, 0);

    run_op(4'd12, 16'h1111, 0, 0, 0);
    chk("illegal.err", err, 1);
    run_op(4'd2, 16'h4242, 0, 1, 0);
    chk("legal.err", err, 0);
    chk("start_wins.ac", ac, 16'h4242);

    // Random traffic, mostly back-to-back
    for (int i = 0; i < 300; i++) begin
      logic [3:0] o;
      logic [SHW-1:0] k;
      o = 4'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0) ? SHW'($urandom) : SHW'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) ldac(W'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        tick();
        chk("idle.done", done, 0);
      end
      run_op(o, W'($urandom), k, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
